// File: rtl/clk_strobe_gen.sv
// Lock-qualified fractional-rate strobe generator: NUM_CH phase accumulators on the PLL clock.
// Optional build macro CLK_STROBE_GEN_SQUARE_OUT_EN adds sq_out, the accumulator MSB per channel.
module clk_strobe_gen #(
    parameter int NUM_CH      = 2,
    parameter int ACC_W       = 32,
    parameter int LOCK_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pll_locked,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [NUM_CH*ACC_W-1:0] incr,
    input  logic                    load,
    output logic [NUM_CH-1:0]       tick,
    output logic                    ready,
    output logic                    rst_out_n
`ifdef CLK_STROBE_GEN_SQUARE_OUT_EN
    ,
    output logic [NUM_CH-1:0]       sq_out
`endif
);

    // state     | meaning
    // WAIT_LOCK | PLL not locked; counter and accumulators held at 0
    // STABLE    | PLL locked, counting consecutive locked cycles
    // RUN       | lock qualified; accumulators advance, ready=1
    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RUN       = 2'd2
    } state_t;

    localparam int CNT_W = $clog2(LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOCK_MAX  = CNT_W'(LOCK_CYCLES);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] lock_cnt;
    logic             run_en;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= WAIT_LOCK;
            lock_cnt  <= '0;
            ready     <= 1'b0;
            rst_out_n <= 1'b0;
        end else begin
            rst_out_n <= ready;
            if (!pll_locked) begin
                state    <= WAIT_LOCK;
                lock_cnt <= '0;
                ready    <= 1'b0;
            end else begin
                case (state)
                    WAIT_LOCK: begin
                        state    <= STABLE;
                        lock_cnt <= CNT_ONE;
                        ready    <= 1'b0;
                    end
                    STABLE: begin
                        // The edge that brings the count to LOCK_CYCLES is the one that enters RUN;
                        // the >= also covers LOCK_CYCLES=1, where the count is already there.
                        if (lock_cnt >= LOCK_LAST) begin
                            state    <= RUN;
                            lock_cnt <= LOCK_MAX;
                            ready    <= 1'b1;
                        end else begin
                            lock_cnt <= lock_cnt + CNT_ONE;
                            ready    <= 1'b0;
                        end
                    end
                    RUN: begin
                        ready <= 1'b1;
                    end
                    default: begin
                        state    <= WAIT_LOCK;
                        lock_cnt <= '0;
                        ready    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign run_en = (state == RUN) && pll_locked;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [ACC_W-1:0] shadow_incr;
        logic [ACC_W-1:0] acc;
        logic [ACC_W:0]   sum;
        logic             tick_q;

        assign sum = {1'b0, acc} + {1'b0, shadow_incr};

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                shadow_incr <= '0;
            end else if (load) begin
                shadow_incr <= incr[i*ACC_W +: ACC_W];
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n || !run_en || !ch_en[i]) begin
                acc    <= '0;
                tick_q <= 1'b0;
            end else begin
                acc    <= sum[ACC_W-1:0];
                tick_q <= sum[ACC_W];
            end
        end

        assign tick[i] = tick_q;

`ifdef CLK_STROBE_GEN_SQUARE_OUT_EN
        logic sq_q;

        // Tracks the MSB of the accumulator value being written, so it stays aligned with acc.
        always_ff @(posedge clk) begin
            if (!rst_n || !run_en || !ch_en[i]) begin
                sq_q <= 1'b0;
            end else begin
                sq_q <= sum[ACC_W-1];
            end
        end

        assign sq_out[i] = sq_q;
`endif
    end

endmodule

// File: tb/tb_clk_strobe_gen.sv
// Self-checking bench for clk_strobe_gen (ACC_W=8, LOCK_CYCLES=16) against a phase/lock-streak model.
module tb_clk_strobe_gen;

    localparam int NCH  = 2;
    localparam int AW   = 8;
    localparam int LOCK = 16;
    localparam int MOD  = 1 << AW;

    logic              clk;
    logic              rst_n;
    logic              pll_locked;
    logic [NCH-1:0]    ch_en;
    logic [NCH*AW-1:0] incr;
    logic              load;
    logic [NCH-1:0]    tick;
    logic              ready;
    logic              rst_out_n;
`ifdef CLK_STROBE_GEN_SQUARE_OUT_EN
    logic [NCH-1:0]    sq_out;
`endif

    int checks = 0;
    int errors = 0;

    // reference model state
    int             m_streak;
    logic           m_ready;
    logic           m_rstout;
    int             m_phase  [NCH];
    int             m_shadow [NCH];
    logic [NCH-1:0] m_tick;

    clk_strobe_gen #(
        .NUM_CH      (NCH),
        .ACC_W       (AW),
        .LOCK_CYCLES (LOCK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .ch_en      (ch_en),
        .incr       (incr),
        .load       (load),
        .tick       (tick),
        .ready      (ready),
        .rst_out_n  (rst_out_n)
`ifdef CLK_STROBE_GEN_SQUARE_OUT_EN
        ,
        .sq_out     (sq_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_edge();
        int p;
        logic run;
        if (!rst_n) begin
            m_streak = 0;
            m_ready  = 1'b0;
            m_rstout = 1'b0;
            m_tick   = '0;
            for (int c = 0; c < NCH; c++) begin
                m_phase[c]  = 0;
                m_shadow[c] = 0;
            end
        end else begin
            run = m_ready && pll_locked;
            for (int c = 0; c < NCH; c++) begin
                if (run && ch_en[c]) begin
                    p          = m_phase[c] + m_shadow[c];
                    m_tick[c]  = (p >= MOD);
                    m_phase[c] = p % MOD;
                end else begin
                    m_tick[c]  = 1'b0;
                    m_phase[c] = 0;
                end
            end
            if (load) begin
                for (int c = 0; c < NCH; c++) m_shadow[c] = int'(incr[c*AW +: AW]);
            end
            m_rstout = m_ready;
            m_streak = pll_locked ? m_streak + 1 : 0;
            m_ready  = (m_streak >= LOCK);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_incr(input int i0, input int i1);
        incr = {i1[AW-1:0], i0[AW-1:0]};
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pll_locked = 1'b0; ch_en = '0; load = 1'b0; incr = '0;
        repeat (3) cycle();
        checks++;
        if (ready !== 1'b0 || rst_out_n !== 1'b0 || tick !== '0) begin
            errors++;
            $display("FAIL reset: ready=%b rst_out_n=%b tick=%b, want 0 0 00", ready, rst_out_n, tick);
        end
    endtask

    task automatic test_lock_qual();
        int rdy_edge = -1;
        int rst_edge = -1;
        rst_n = 1'b1; pll_locked = 1'b1;
        for (int n = 1; n <= LOCK + 4; n++) begin
            cycle();
            if (ready === 1'b1 && rdy_edge < 0) rdy_edge = n;
            if (rst_out_n === 1'b1 && rst_edge < 0) rst_edge = n;
            checks++;
            if (ready !== m_ready || rst_out_n !== m_rstout) begin
                errors++;
                $display("FAIL lock_qual edge %0d: ready=%b rst_out_n=%b, want %b %b", n, ready, rst_out_n, m_ready, m_rstout);
            end
        end
        checks++;
        if (rdy_edge != LOCK || rst_edge != LOCK + 1) begin
            errors++;
            $display("FAIL lock_qual_timing: ready edge %0d rst_out_n edge %0d, want %0d %0d", rdy_edge, rst_edge, LOCK, LOCK + 1);
        end
    endtask

    task automatic test_lock_glitch();
        int rdy_edge = -1;
        rst_n = 1'b0; cycle(); rst_n = 1'b1;
        pll_locked = 1'b1;
        repeat (10) cycle();
        pll_locked = 1'b0;
        cycle();
        checks++;
        if (ready !== 1'b0 || m_ready !== 1'b0) begin
            errors++;
            $display("FAIL glitch_drop: ready=%b, want 0", ready);
        end
        pll_locked = 1'b1;
        for (int n = 1; n <= LOCK + 2; n++) begin
            cycle();
            if (ready === 1'b1 && rdy_edge < 0) rdy_edge = n;
        end
        checks++;
        if (rdy_edge != LOCK) begin
            errors++;
            $display("FAIL glitch_relock: ready rose at relock edge %0d, want %0d", rdy_edge, LOCK);
        end
    endtask

    task automatic test_rate();
        rst_n = 1'b0; cycle();
        rst_n = 1'b1; pll_locked = 1'b0; ch_en = 2'b11;
        set_incr(64, 128); load = 1'b1;
        cycle();
        load = 1'b0; set_incr(0, 0);
        pll_locked = 1'b1;
        repeat (LOCK) cycle();
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL rate_ready: ready=%b, want 1", ready);
        end
        for (int k = 1; k <= 16; k++) begin
            cycle();
            checks++;
            if (tick[0] !== ((k % 4) == 0) || tick[1] !== ((k % 2) == 0)) begin
                errors++;
                $display("FAIL rate run edge %0d: tick=%b, want %b%b", k, tick, (k % 2) == 0, (k % 4) == 0);
            end
        end
    endtask

    task automatic test_enable_load();
        ch_en = 2'b10;
        cycle();
        checks++;
        if (tick[0] !== 1'b0) begin
            errors++;
            $display("FAIL disable: tick0=%b, want 0", tick[0]);
        end
        repeat (6) begin
            cycle();
            checks++;
            if (tick !== m_tick || tick[0] !== 1'b0) begin
                errors++;
                $display("FAIL disabled_hold: tick=%b, want %b", tick, m_tick);
            end
        end
        ch_en = 2'b11;
        for (int k = 1; k <= 4; k++) begin
            cycle();
            checks++;
            if (tick[0] !== (k == 4)) begin
                errors++;
                $display("FAIL reenable edge %0d: tick0=%b, want %b", k, tick[0], k == 4);
            end
        end
        cycle();
        set_incr(128, 128); load = 1'b1;
        cycle();
        load = 1'b0; set_incr(0, 0);
        for (int k = 1; k <= 12; k++) begin
            cycle();
            checks++;
            if (tick !== m_tick) begin
                errors++;
                $display("FAIL load_rate edge %0d: tick=%b, want %b", k, tick, m_tick);
            end
        end
    endtask

    task automatic test_fractional();
        int cnt = 0;
        logic prev = 1'b0;
        set_incr(3, 0); load = 1'b1;
        cycle();
        load = 1'b0;
        cycle();
        for (int k = 0; k < MOD; k++) begin
            cycle();
            if (tick[0] === 1'b1) cnt++;
            checks++;
            if ((prev === 1'b1 && tick[0] === 1'b1) || tick !== m_tick) begin
                errors++;
                $display("FAIL fractional edge %0d: tick=%b prev=%b, want %b single-cycle", k, tick, prev, m_tick);
            end
            prev = tick[0];
        end
        checks++;
        if (cnt != 3) begin
            errors++;
            $display("FAIL fractional_count: %0d ticks in 256 cycles, want 3", cnt);
        end
    endtask

    task automatic test_lock_loss();
        set_incr(64, 128); load = 1'b1;
        cycle();
        load = 1'b0;
        repeat (3) cycle();
        pll_locked = 1'b0;
        cycle();
        checks++;
        if (ready !== 1'b0 || rst_out_n !== 1'b1 || tick !== '0) begin
            errors++;
            $display("FAIL lock_loss_1: ready=%b rst_out_n=%b tick=%b, want 0 1 00", ready, rst_out_n, tick);
        end
        cycle();
        checks++;
        if (ready !== 1'b0 || rst_out_n !== 1'b0 || tick !== '0) begin
            errors++;
            $display("FAIL lock_loss_2: ready=%b rst_out_n=%b tick=%b, want 0 0 00", ready, rst_out_n, tick);
        end
    endtask

    task automatic test_reset_with_load();
        int cnt = 0;
        pll_locked = 1'b1;
        repeat (LOCK + 2) cycle();
        rst_n = 1'b0; load = 1'b1; set_incr(200, 255);
        cycle();
        rst_n = 1'b1; load = 1'b0; set_incr(0, 0);
        repeat (LOCK) cycle();
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_load_ready: ready=%b, want 1", ready);
        end
        repeat (40) begin
            cycle();
            if (tick !== '0) cnt++;
        end
        checks++;
        if (cnt != 0) begin
            errors++;
            $display("FAIL reset_load_ticks: %0d cycles with ticks, want 0", cnt);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            rst_n      = ($urandom_range(0, 499) != 0);
            pll_locked = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 31) == 0) ch_en = NCH'($urandom);
            load = ($urandom_range(0, 15) == 0);
            incr = (NCH*AW)'($urandom);
            cycle();
            checks++;
            if (tick !== m_tick || ready !== m_ready || rst_out_n !== m_rstout) begin
                errors++;
                $display("FAIL random %0d: tick=%b ready=%b rst_out_n=%b, want %b %b %b", k, tick, ready, rst_out_n, m_tick, m_ready, m_rstout);
            end
        end
    endtask

    initial begin
        m_streak = 0; m_ready = 1'b0; m_rstout = 1'b0; m_tick = '0;
        for (int c = 0; c < NCH; c++) begin
            m_phase[c] = 0;
            m_shadow[c] = 0;
        end
        test_reset();
        test_lock_qual();
        test_lock_glitch();
        test_rate();
        test_enable_load();
        test_fractional();
        test_lock_loss();
        test_reset_with_load();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
